// File: rtl/alu_req_sched_pkg.sv
// Shared types and widths for the ALU request scheduler.
// Optional feature macro: ALU_REQ_SCHED_FIXED_PRIO_EN (see alu_rr_arbiter).
package alu_ctrl_pkg;

    localparam int OPND_W = 4;
    localparam int RES_W  = 5;
    localparam int LAT_W  = 3;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_NOT_A = 2'b10,
        OP_ROR_B = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } sched_state_t;

endpackage

// File: rtl/alu_req_sched_if.sv
// Requester and response channels of the ALU request scheduler.
// The scheduler uses the slave view, the requester/consumer side the master view.
interface alu_req_sched_if
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [2*NUM_REQ-1:0]      req_opcode;
    logic [OPND_W*NUM_REQ-1:0] req_a;
    logic [OPND_W*NUM_REQ-1:0] req_b;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [RES_W-1:0]          rsp_c;
    logic [ID_W-1:0]           rsp_id;

    modport slave (
        input  req_valid,
        input  req_opcode,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_c,
        output rsp_id
    );

    modport master (
        output req_valid,
        output req_opcode,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_c,
        input  rsp_id
    );

endinterface

// File: rtl/alu_req_sched_arb.sv
// Requester arbiter for the ALU scheduler.
// Default: round-robin search starting at rr_ptr.
// With ALU_REQ_SCHED_FIXED_PRIO_EN defined: lowest asserted index wins and
// the rr_ptr input disappears.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
`ifndef ALU_REQ_SCHED_FIXED_PRIO_EN
    input  logic [ID_W-1:0]    rr_ptr,
`endif
    input  logic               grant_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic found;

`ifdef ALU_REQ_SCHED_FIXED_PRIO_EN

    // Pick the lowest-numbered pending requester.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end

`else

    // One extra bit so the pointer+offset sum can be wrapped without modulo.
    localparam int SUM_W = ID_W + 1;

    logic [SUM_W-1:0] cand;

    // Walk the requesters starting at rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + SUM_W'(i);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (!found && req[cand[ID_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

`endif

    // Turn the winner into a one-hot strobe, only when granting is allowed.
    always_comb begin
        grant = '0;
        if (grant_en && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_req_sched.sv
// Shares one 4-bit signed ALU between NUM_REQ requesters.
// One operation is in flight at a time: accept, wait ALU_LAT clocks,
// return the tagged result and wait for the consumer.
// Optional feature macro: ALU_REQ_SCHED_FIXED_PRIO_EN (fixed priority,
// lowest index wins, no round-robin pointer).
module alu_req_sched
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = 1,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    alu_req_sched_if.slave           bus,
    output logic [1:0]               alu_opcode,
    output logic signed [OPND_W-1:0] alu_a,
    output logic signed [OPND_W-1:0] alu_b,
    input  logic signed [RES_W-1:0]  alu_c
);

    sched_state_t       state;
    sched_state_t       state_next;

    logic [LAT_W-1:0]   lat_cnt;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_en;
    logic               granted;

    alu_op_t            sel_op;
    logic [OPND_W-1:0]  sel_a;
    logic [OPND_W-1:0]  sel_b;

    logic               rsp_valid_q;
    logic [RES_W-1:0]   rsp_c_q;
    logic [ID_W-1:0]    rsp_id_q;

    // Granting is only legal while idle and out of reset, so req_ready is
    // guaranteed low during reset even though the state is forced to IDLE.
    assign grant_en = (state == IDLE) && reset;
    assign granted  = |grant;

`ifdef ALU_REQ_SCHED_FIXED_PRIO_EN

    alu_rr_arbiter #(
        .NUM_REQ  (NUM_REQ)
    ) u_arb (
        .req      (bus.req_valid),
        .grant_en (grant_en),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

`else

    logic [ID_W-1:0] rr_ptr;

    alu_rr_arbiter #(
        .NUM_REQ  (NUM_REQ)
    ) u_arb (
        .req      (bus.req_valid),
        .rr_ptr   (rr_ptr),
        .grant_en (grant_en),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    // Advance the round-robin pointer past the winner, only on a grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (granted) begin
            if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end

`endif

    // Select the winning requester's opcode and operands from the packed buses.
    always_comb begin
        sel_op = OP_ADD;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_op = alu_op_t'(bus.req_opcode[2*i +: 2]);
                sel_a  = bus.req_a[OPND_W*i +: OPND_W];
                sel_b  = bus.req_b[OPND_W*i +: OPND_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, wait out the ALU latency, hand off the result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (granted) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (lat_cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, latency counter and response registers; ALU inputs stay
    // frozen from accept until the next accept so the ALU sees stable values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_opcode  <= 2'b00;
            alu_a       <= '0;
            alu_b       <= '0;
            lat_cnt     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (granted) begin
                        alu_opcode <= sel_op;
                        alu_a      <= sel_a;
                        alu_b      <= sel_b;
                        rsp_id_q   <= grant_idx;
                        lat_cnt    <= LAT_W'(ALU_LAT);
                    end
                end
                EXEC: begin
                    if (lat_cnt == '0) begin
                        rsp_c_q     <= alu_c;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_c     = rsp_c_q;
    assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_req_sched.sv
// Directed bench for alu_req_sched with a latency-1 ALU model.
// Expectations follow ALU_REQ_SCHED_FIXED_PRIO_EN when it is defined.
module tb_alu_req_sched;

    import alu_ctrl_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ALU_LAT = 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] aluOpcode;
    logic [3:0] aluA;
    logic [3:0] aluB;
    logic [4:0] aluC = '0;

    int total = 0;
    int bad   = 0;

    logic [1:0] reqOp [NUM_REQ];
    logic [3:0] reqA  [NUM_REQ];
    logic [3:0] reqB  [NUM_REQ];
    logic [4:0] expC  [NUM_REQ];

    alu_req_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

    alu_req_sched #(
        .NUM_REQ   (NUM_REQ),
        .ALU_LAT   (ALU_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .alu_opcode(aluOpcode),
        .alu_a     (aluA),
        .alu_b     (aluB),
        .alu_c     (aluC)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Reference 4-bit signed ALU producing a 5-bit signed result.
    function automatic logic [4:0] aluModel(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] ea;
        logic [4:0] eb;
        ea = {a[3], a};
        eb = {b[3], b};
        case (op)
            2'b00:   return ea + eb;
            2'b01:   return ea - eb;
            2'b10:   return ~ea;
            default: return {4'b0000, |b};
        endcase
    endfunction

    // One-clock ALU: result registered from the scheduler's operand outputs.
    always @(posedge clk) aluC <= aluModel(aluOpcode, aluA, aluB);

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [1:0] op, input logic [3:0] a,
                                 input logic [3:0] b, input logic [4:0] c);
        reqOp[id] = op;
        reqA[id]  = a;
        reqB[id]  = b;
        expC[id]  = c;
        bus.req_opcode[2*id +: 2] = op;
        bus.req_a[4*id +: 4]      = a;
        bus.req_b[4*id +: 4]      = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect requester id to be granted now, then follow it to its response.
    task automatic issueTxn(input int id);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        #1;
        checkOutput($sformatf("grant%0d", id), 32'(bus.req_ready), 32'(oh));
        tick();
        checkOutput($sformatf("aluop%0d", id), 32'(aluOpcode), 32'(reqOp[id]));
        checkOutput($sformatf("alua%0d", id), 32'(aluA), 32'(reqA[id]));
        checkOutput($sformatf("alub%0d", id), 32'(aluB), 32'(reqB[id]));
        checkOutput($sformatf("rdyexec%0d", id), 32'(bus.req_ready), 32'(0));
        tick();
        checkOutput($sformatf("early%0d", id), 32'(bus.rsp_valid), 32'(0));
        tick();
        checkOutput($sformatf("rspv%0d", id), 32'(bus.rsp_valid), 32'(1));
        checkOutput($sformatf("rspc%0d", id), 32'(bus.rsp_c), 32'(expC[id]));
        checkOutput($sformatf("rspid%0d", id), 32'(bus.rsp_id), 32'(id));
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_opcode = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = 1'b1;

        applyStimulus(0, OP_ADD,   4'd3, 4'd4, 5'd7);
        applyStimulus(1, OP_ADD,   4'd1, 4'd1, 5'd2);
        applyStimulus(2, OP_SUB,   4'h8, 4'd1, 5'b10111);
        applyStimulus(3, OP_NOT_A, 4'd5, 4'd0, 5'b11010);

        // Reset held with every requester pending.
        bus.req_valid = 4'hF;
        reset = 1'b0;
        repeat (3) tick();
        checkOutput("rst_ready", 32'(bus.req_ready), 32'(0));
        checkOutput("rst_rspv",  32'(bus.rsp_valid), 32'(0));
        checkOutput("rst_rspc",  32'(bus.rsp_c),     32'(0));
        checkOutput("rst_rspid", 32'(bus.rsp_id),    32'(0));
        checkOutput("rst_aluop", 32'(aluOpcode),     32'(0));
        checkOutput("rst_alua",  32'(aluA),          32'(0));
        checkOutput("rst_alub",  32'(aluB),          32'(0));

        // First grant after release goes to requester 0.
        reset = 1'b1;
        issueTxn(0);
        tick();
        checkOutput("hs0", 32'(bus.rsp_valid), 32'(0));

`ifdef ALU_REQ_SCHED_FIXED_PRIO_EN
        // Requesters 1 and 3 both pending: 1 must win every time.
        bus.req_valid = 4'b1010;
        applyStimulus(1, OP_ROR_B, 4'd2, 4'd0, 5'd0);
        issueTxn(1);
        tick();
        applyStimulus(1, OP_ROR_B, 4'd0, 4'd6, 5'd1);
        issueTxn(1);
        tick();
        applyStimulus(1, OP_ADD, 4'd7, 4'd1, 5'b01000);
        issueTxn(1);
        tick();
        checkOutput("fp_hs", 32'(bus.rsp_valid), 32'(0));
`else
        // Continuous requests: rotation 1,2,3,0 after the first grant to 0.
        for (int n = 1; n <= 4; n++) begin
            issueTxn(n % NUM_REQ);
            tick();
            checkOutput("hs", 32'(bus.rsp_valid), 32'(0));
        end

        // Back-pressure: response must hold while the consumer stalls.
        bus.rsp_ready = 1'b0;
        issueTxn(1);
        for (int n = 0; n < 5; n++) begin
            tick();
            checkOutput("bp_rspv",  32'(bus.rsp_valid), 32'(1));
            checkOutput("bp_rspc",  32'(bus.rsp_c),     32'(2));
            checkOutput("bp_rspid", 32'(bus.rsp_id),    32'(1));
            checkOutput("bp_ready", 32'(bus.req_ready), 32'(0));
        end
        bus.rsp_ready = 1'b1;
        #1;
        checkOutput("bp_noacc", 32'(bus.req_ready), 32'(0));
        tick();
        checkOutput("bp_hs", 32'(bus.rsp_valid), 32'(0));
        issueTxn(2);
        tick();

        // Reset while requester 3's Not_A is executing.
        #1;
        checkOutput("grant3", 32'(bus.req_ready), 32'(4'b1000));
        tick();
        checkOutput("ex_aluop", 32'(aluOpcode), 32'(2));
        checkOutput("ex_alua",  32'(aluA),      32'(5));
        reset = 1'b0;
        #1;
        checkOutput("mid_ready", 32'(bus.req_ready), 32'(0));
        checkOutput("mid_rspv",  32'(bus.rsp_valid), 32'(0));
        checkOutput("mid_aluop", 32'(aluOpcode),     32'(0));
        checkOutput("mid_alua",  32'(aluA),          32'(0));
        repeat (2) begin
            tick();
            checkOutput("mid_norsp", 32'(bus.rsp_valid), 32'(0));
        end
        reset = 1'b1;
        issueTxn(0);
        tick();
        checkOutput("post_hs", 32'(bus.rsp_valid), 32'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
